// File: rtl/fanin_serializer.sv
// Purpose: accepts a WIDTH-bit word over valid/ready and emits it one bit per transfer, LSB- or MSB-first.
// Latency: the first bit is valid the cycle after acceptance; a word takes WIDTH transfer cycles.
// Backpressure: ser_ready=0 freezes the current bit; in_ready reopens on the last-bit transfer, so words run back-to-back with no bubble.
module fanin_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_data,
  output logic             ser_last,
  output logic [7:0]       word_count
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [IDXW-1:0]  idx;
  logic             at_last;
  logic             xfer;
  logic             last_xfer;
  logic             accept;

  assign at_last = (idx == LAST_IDX);

  // Move the register one place toward whichever end feeds ser_data.
  always_comb begin
    shreg_shifted = shreg;
    if (MSB_FIRST) begin
      shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs; ser_ready reaches in_ready only via the last-bit transfer.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_last  = at_last;
        ser_data  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        xfer      = ser_ready;
        last_xfer = ser_ready && at_last;
        in_ready  = last_xfer;
        accept    = last_xfer && in_valid;
        if (last_xfer && !in_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit index: load on acceptance, advance on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (accept) begin
      shreg <= in_data;
      idx   <= '0;
    end else if (xfer) begin
      shreg <= shreg_shifted;
      idx   <= at_last ? '0 : idx + IDXW'(1);
    end
  end

  // Completed-word counter, wraps naturally at 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= 8'd0;
    end else if (last_xfer) begin
      word_count <= word_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fanin_serializer.sv
// Directed bench for fanin_serializer: LSB-first instance carries most steps,
// an MSB-first instance checks bit ordering from the other end.
module tb_fanin_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        ser_ready;
  logic        ser_valid;
  logic        ser_data;
  logic        ser_last;
  logic [7:0]  word_count;

  logic        m_in_valid;
  logic [15:0] m_in_data;
  logic        m_in_ready;
  logic        m_ser_ready;
  logic        m_ser_valid;
  logic        m_ser_data;
  logic        m_ser_last;
  logic [7:0]  m_word_count;

  int errors = 0;
  int checks = 0;
  int gaps   = 0;

  fanin_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ser_ready  (ser_ready),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_last   (ser_last),
    .word_count (word_count)
  );

  fanin_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (m_in_valid),
    .in_data    (m_in_data),
    .in_ready   (m_in_ready),
    .ser_ready  (m_ser_ready),
    .ser_valid  (m_ser_valid),
    .ser_data   (m_ser_data),
    .ser_last   (m_ser_last),
    .word_count (m_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one word on the LSB-first instance and check every bit; optionally stall at one index.
  task automatic run_word(input logic [15:0] d, input int stall_at, input int stall_len,
                          input logic [7:0] exp_wc);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    ser_ready = 1'b1;
    #1 chk("accept_rdy", {15'd0, in_ready}, 16'd1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      if (k == stall_at) begin
        ser_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk("stall_vld",  {15'd0, ser_valid}, 16'd1);
          chk("stall_dat",  {15'd0, ser_data},  {15'd0, d[k]});
          chk("stall_last", {15'd0, ser_last},  {15'd0, (k == 15)});
          chk("stall_rdy",  {15'd0, in_ready},  16'd0);
          @(negedge clk);
        end
        ser_ready = 1'b1;
      end
      #1;
      chk("bit_vld",  {15'd0, ser_valid}, 16'd1);
      chk("bit_dat",  {15'd0, ser_data},  {15'd0, d[k]});
      chk("bit_last", {15'd0, ser_last},  {15'd0, (k == 15)});
      chk("bit_rdy",  {15'd0, in_ready},  {15'd0, (k == 15)});
    end
    @(negedge clk);
    #1;
    chk("word_idle", {15'd0, ser_valid}, 16'd0);
    chk("word_cnt",  {8'd0, word_count}, {8'd0, exp_wc});
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'h0000;
    ser_ready   = 1'b1;
    m_in_valid  = 1'b0;
    m_in_data   = 16'h0000;
    m_ser_ready = 1'b1;

    // Reset values while rst_n is low.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready",  {15'd0, in_ready},  16'd1);
    chk("rst_ser_valid", {15'd0, ser_valid}, 16'd0);
    chk("rst_ser_data",  {15'd0, ser_data},  16'd0);
    chk("rst_ser_last",  {15'd0, ser_last},  16'd0);
    chk("rst_word_cnt",  {8'd0, word_count}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LSB-first word A5C3: bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
    run_word(16'hA5C3, -1, 0, 8'd1);

    // MSB-first word 8001: 1, fourteen zeros, 1 with ser_last.
    @(negedge clk);
    m_in_valid = 1'b1;
    m_in_data  = 16'h8001;
    #1 chk("msb_accept_rdy", {15'd0, m_in_ready}, 16'd1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      m_in_valid = 1'b0;
      m_in_data  = 16'($urandom);
      #1;
      chk("msb_vld",  {15'd0, m_ser_valid}, 16'd1);
      chk("msb_dat",  {15'd0, m_ser_data},  {15'd0, (k == 0 || k == 15)});
      chk("msb_last", {15'd0, m_ser_last},  {15'd0, (k == 15)});
    end
    @(negedge clk);
    #1 chk("msb_word_cnt", {8'd0, m_word_count}, 16'd1);

    // Back-to-back FFFF then 0000 with in_valid held: 32 valid cycles, no gap.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    #1 chk("b2b_accept_rdy", {15'd0, in_ready}, 16'd1);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c == 0)  in_data  = 16'h0000;
      if (c == 16) in_valid = 1'b0;
      #1;
      chk("b2b_vld",  {15'd0, ser_valid}, 16'd1);
      chk("b2b_dat",  {15'd0, ser_data},  {15'd0, (c < 16)});
      chk("b2b_last", {15'd0, ser_last},  {15'd0, (c % 16 == 15)});
      chk("b2b_rdy",  {15'd0, in_ready},  {15'd0, (c % 16 == 15)});
    end
    @(negedge clk);
    #1;
    chk("b2b_idle", {15'd0, ser_valid}, 16'd0);
    chk("b2b_cnt",  {8'd0, word_count}, 16'd3);

    // Five-cycle stall at bit index 7; bit 7 of 0080 is the lone 1.
    run_word(16'h0080, 7, 5, 8'd4);

    // Reset mid-word at bit index 9.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst2_cnt", {8'd0, word_count}, 16'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1;
    chk("pre_rst_vld",  {15'd0, ser_valid}, 16'd1);
    chk("pre_rst_last", {15'd0, ser_last},  16'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld",  {15'd0, ser_valid}, 16'd0);
    chk("async_rst_rdy",  {15'd0, in_ready},  16'd1);
    chk("async_rst_dat",  {15'd0, ser_data},  16'd0);
    chk("async_rst_cnt",  {8'd0, word_count}, 16'd0);
    @(negedge clk);
    #1 chk("held_rst_vld", {15'd0, ser_valid}, 16'd0);
    // First edge after release accepts a word.
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0001;
    #1 chk("post_rst_rdy", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_rst_vld", {15'd0, ser_valid}, 16'd1);
    chk("post_rst_dat", {15'd0, ser_data},  16'd1);
    repeat (16) @(negedge clk);
    #1;
    chk("post_rst_idle", {15'd0, ser_valid}, 16'd0);
    chk("post_rst_cnt",  {8'd0, word_count}, 16'd1);

    // 257 back-to-back words: counter wraps through 0 and ends at 1.
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst3_cnt", {8'd0, word_count}, 16'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int c = 0; c < 257 * 16; c++) begin
      @(negedge clk);
      if (c == 256 * 16) in_valid = 1'b0;
      in_data = 16'($urandom);
      #1;
      if (!ser_valid) gaps++;
      if (c == 256 * 16) chk("wrap_cnt", {8'd0, word_count}, 16'd0);
    end
    chk("long_gaps", 16'(gaps), 16'd0);
    @(negedge clk);
    #1;
    chk("long_idle", {15'd0, ser_valid}, 16'd0);
    chk("long_cnt",  {8'd0, word_count}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fanin_serializer.md
FANIN_SERIALIZER -- requirements
Module: fanin_serializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the parallel word width in bits (legal 2..64).
REQ-002 The module SHALL have parameter MSB_FIRST, default 0; 0 = bit 0 shifted first, 1 = bit WIDTH-1 shifted first.
REQ-003 The module SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 The module SHALL have port in_valid  input  1  a parallel word is offered.
REQ-006 The module SHALL have port in_data  input  WIDTH  the parallel word; sampled only on acceptance.
REQ-007 The module SHALL have port in_ready  output  1  the serializer can accept a word this cycle.
REQ-008 The module SHALL have port ser_ready  input  1  the downstream sink takes the current serial bit.
REQ-009 The module SHALL have port ser_valid  output  1  ser_data holds a valid bit.
REQ-010 The module SHALL have port ser_data  output  1  the current serial bit.
REQ-011 The module SHALL have port ser_last  output  1  the current bit is the final bit of the word.
REQ-012 The module SHALL have port word_count  output  8  count of fully transmitted words, modulo 256.

Function
REQ-013 The FSM SHALL have two states: IDLE (no word held) and SHIFT (word held, bits pending).
REQ-014 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into a WIDTH-bit shift register and the bit index is cleared to 0.
REQ-015 in_ready SHALL be 1 in IDLE, and SHALL be 1 in SHIFT only when bit index = WIDTH-1 and ser_ready=1; ser_ready is the only combinational path to in_ready.
REQ-016 ser_valid SHALL be 1 exactly while in SHIFT; first bit appears the cycle after acceptance (latency 1).
REQ-017 A bit SHALL transfer on a rising edge where ser_valid=1 and ser_ready=1; the bit index then increments and the register shifts by one toward the output end.
REQ-018 While ser_valid=1 and ser_ready=0, ser_data, ser_last and the bit index SHALL hold unchanged.
REQ-019 ser_data SHALL equal captured bit k at bit index k (MSB_FIRST=0), or bit WIDTH-1-k (MSB_FIRST=1).
REQ-020 ser_last SHALL be 1 only when ser_valid=1 and bit index = WIDTH-1.
REQ-021 On transfer of the last bit: with in_valid=1, the new word SHALL be accepted on the same edge, SHIFT SHALL be retained with index 0 (no bubble); otherwise the FSM SHALL return to IDLE.
REQ-022 word_count SHALL increment by 1 on each last-bit transfer and SHALL wrap from 255 to 0.
REQ-023 in_data changes while not accepted SHALL have no effect on ser_data.
REQ-024 One word of WIDTH bits SHALL take exactly WIDTH transfer cycles when ser_ready is held 1.

Reset
REQ-025 While rst_n=0, the FSM SHALL be IDLE and outputs SHALL be: in_ready=1, ser_valid=0, ser_data=0, ser_last=0, word_count=0; the shift register and bit index SHALL be 0.
REQ-026 Assertion of rst_n mid-word SHALL discard the word immediately with no further ser_valid, and word_count SHALL not increment.
REQ-027 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-028 Bench SHALL cover: WIDTH=16, MSB_FIRST=0, in_data=16'hA5C3, ser_ready=1 -> ser_data sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; ser_last only on 16th bit; word_count 0->1.
REQ-029 Bench SHALL cover: MSB_FIRST=1, in_data=16'h8001 -> first bit 1, bits 2..15 are 0, 16th bit 1 with ser_last=1.
REQ-030 Bench SHALL cover: two words 16'hFFFF then 16'h0000, in_valid held 1 -> 32 consecutive ser_valid cycles with no gap; in_ready pulses 1 only on the 16th bit cycle.
REQ-031 Bench SHALL cover: ser_ready=0 for 5 cycles at bit index 7 -> ser_data, ser_last and index frozen; in_ready=0; transmission resumes at bit 7.
REQ-032 Bench SHALL cover: rst_n=0 at bit index 9 -> ser_valid=0 and in_ready=1 asynchronously; word_count unchanged at 0.
REQ-033 Bench SHALL cover: 257 back-to-back words -> word_count reads 1 after final last-bit transfer.
